sim_ram_hs: RTL and testbench

- Simulation-only, byte-addressable external memory model. Parametrised in data width, depth and access latency.
- Uses a valid/ready request channel and a valid/ready response channel.
- Models wait states, size errors and sign-extended loads.
- Sits behind the core's load/store unit in the block-level testbenches. Replaces the fixed zero-latency RAM model.

---
 rtl/sim_ram_hs.sv | 103 ++++++++++
 tb/tb_sim_ram_hs.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ram_hs.sv
// rtl/sim_ram_hs.sv - byte-addressable latency memory model with valid/ready request and response channels
// Optional macro SIM_RAM_ALIGN_CHECK_EN: misaligned requests are answered with rsp_err_o.
module sim_ram_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [7:0]        mem [DEPTH];
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [3:0]        nbytes;
  logic              illegal;
  logic              sign_bit;
  logic [DATA_W-1:0] rd_word;

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);

  always_comb begin
    nbytes  = 4'd1 << req_size_i;
    illegal = (nbytes > 4'(NB));
`ifdef SIM_RAM_ALIGN_CHECK_EN
    if ((req_addr_i & ADDR_W'(nbytes - 4'd1)) != '0) illegal = 1'b1;
`endif
  end

  // Gather bytes with address wrap, then fill the upper bytes with zeros or the sign.
  always_comb begin
    rd_word  = '0;
    sign_bit = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) < nbytes) begin
        rd_word[8*k +: 8] = mem[ADDR_W'(req_addr_i + ADDR_W'(k))];
        if (4'(k) == nbytes - 4'd1) sign_bit = rd_word[8*k + 7];
      end
    end
    for (int k = 0; k < NB; k++) begin
      if ((4'(k) >= nbytes) && req_signed_i && sign_bit) rd_word[8*k +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            rsp_err_o   <= illegal;
            rsp_rdata_o <= (!illegal && !req_we_i) ? rd_word : '0;
            if (!illegal && req_we_i) begin
              for (int k = 0; k < NB; k++) begin
                if (4'(k) < nbytes)
                  mem[ADDR_W'(req_addr_i + ADDR_W'(k))] <= req_wdata_i[8*k +: 8];
              end
            end
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ram_hs.sv
// tb/tb_sim_ram_hs.sv - directed self-checking bench for sim_ram_hs
module tb_sim_ram_hs;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  sim_ram_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns the response and the number of negedges from accept to valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b rdata=%h err=%b want 0 1 00000000 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_rw;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== LATENCY) begin
      n_fail++;
      $display("FAIL word_write: rdata=%h err=%b lat=%0d want 00000000 0 %0d", rd, er, lat, LATENCY);
    end
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LATENCY) begin
      n_fail++;
      $display("FAIL word_read: rdata=%h err=%b lat=%0d want deadbeef 0 %0d", rd, er, lat, LATENCY);
    end
  endtask

  task automatic test_sign_ext;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b00, 1'b0, 16'h0020, 32'h00000080, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_signed: rdata=%h err=%b want ffffff80 0", rd, er);
    end
    do_req(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin
      n_fail++;
      $display("FAIL byte_unsigned: rdata=%h want 00000080", rd);
    end
    do_req(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin
      n_fail++;
      $display("FAIL half_unsigned: rdata=%h want 00000080", rd);
    end
    do_req(1'b0, 2'b01, 1'b1, 16'h0020, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin
      n_fail++;
      $display("FAIL half_signed_pos: rdata=%h want 00000080", rd);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat;
    logic [15:0] addrs [4];
    logic [7:0]  exp_b [4];
    addrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
`ifdef SIM_RAM_ALIGN_CHECK_EN
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
`endif
    do_req(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'h11223344, rd, er, lat);
    n_checks++;
`ifdef SIM_RAM_ALIGN_CHECK_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_write_misaligned: err=%b rdata=%h want 1 00000000", er, rd);
    end
`else
    if (er !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_write: err=%b want 0", er);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'b00, 1'b0, addrs[i], 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== {24'h0, exp_b[i]}) begin
        n_fail++;
        $display("FAIL wrap_byte[%h]: rdata=%h want %h", addrs[i], rd, {24'h0, exp_b[i]});
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 16'hFFFE, 32'h0, rd, er, lat);
    n_checks++;
`ifdef SIM_RAM_ALIGN_CHECK_EN
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_read_misaligned: rdata=%h err=%b want 00000000 1", rd, er);
    end
`else
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_read: rdata=%h err=%b want 11223344 0", rd, er);
    end
`endif
  endtask

  task automatic test_size_err;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'b11, 1'b0, 16'h0040, 32'hAAAAAAAA, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== LATENCY) begin
      n_fail++;
      $display("FAIL size_err: err=%b rdata=%h lat=%0d want 1 00000000 %0d", er, rd, lat, LATENCY);
    end
    do_req(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL size_err_nowrite: rdata=%h err=%b want 00000000 0", rd, er);
    end
  endtask

  task automatic test_back_to_back_stall;
    int guard;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 16'h0010; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_wait: ready=%b valid=%b want 0 0", req_ready, rsp_valid);
    end
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b rdata=%h ready=%b want 1 deadbeef 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_no_accept: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_after_retire: ready=%b want 0", req_ready);
    end
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL second_rsp: valid=%b rdata=%h want 1 deadbeef", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat; int stale;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: valid=%b ready=%b rdata=%h want 0 1 00000000",
               rsp_valid, req_ready, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL stale_rsp: valid seen %0d cycles want 0", stale);
    end
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_cleared: rdata=%h err=%b want 00000000 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_sign_ext();
    test_wrap();
    test_size_err();
    test_back_to_back_stall();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
